branch_predict_unit: RTL

Parametrised branch prediction and recovery unit for the 5-stage RISC-V pipeline. It replaces the fixed 2-bit-PHT-input IF mux selector with an internal table of 2-bit saturating counters, which can run in bimodal or gshare mode. An in-order queue tracks in-flight predictions so that several unresolved branches can be outstanding. It drives the IF next-PC mux select, the redirect PC and the flush, and updates its own predictor state when branches resolve in ID/EX.

---
 rtl/bpu_pkg.sv | 40 ++++
 rtl/bpu_pend_fifo.sv | 61 ++++++
 rtl/branch_predict_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared constants, encodings and the pending-branch record for the branch predict unit.
package bpu_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SEL_PC4   = 2'b00,
    SEL_TGT   = 2'b01,
    SEL_REDIR = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Entry fields are sized for the widest supported configuration; narrower
  // instances zero-extend into them and the unused upper bits trim away.
  localparam int PC_W_MAX  = 64;
  localparam int IDX_W_MAX = 16;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    logic                 pred;
    logic [PC_W_MAX-1:0]  fallthrough;
    logic [PC_W_MAX-1:0]  target;
    logic [IDX_W_MAX-1:0] ghr;
  } pend_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != CTR_ST)       nxt = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_pend_fifo.sv
// In-order queue of unresolved predictions: push at tail, pop at head, clear on mispredict.
module bpu_pend_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  pend_entry_t push_data_i,
  output pend_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  pend_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;

  assign head_o  = mem[rd_ptr_q];
  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which slots are valid.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/branch_predict_unit.sv
// 2-bit saturating-counter branch predictor (bimodal or gshare) with in-order
// recovery queue driving the IF next-PC select, redirect PC and flush.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int IDX_W      = 6,
  parameter int MODE       = 0,
  parameter int PEND_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            CE,
  input  logic            if_valid,
  input  logic [6:0]      if_opcode,
  input  logic [PC_W-1:0] if_pc,
  input  logic [PC_W-1:0] if_target,
  input  logic            res_valid,
  input  logic            res_taken,
  output logic [1:0]      pc_sel,
  output logic [PC_W-1:0] redirect_pc,
  output logic            pred_taken,
  output logic            flush,
  output logic            stall_req,
  output logic            res_err,
  output logic [15:0]     br_cnt,
  output logic [15:0]     mis_cnt
);

  localparam int N_CTR = 1 << IDX_W;

  logic [1:0]       pht_q [N_CTR];
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic [15:0]      br_cnt_q, br_cnt_d;
  logic [15:0]      mis_cnt_q, mis_cnt_d;
  logic             res_err_q, res_err_d;

  logic [IDX_W-1:0] idx, head_idx;
  logic             is_br, resolve, mispred, push;
  logic             q_full, q_empty;
  pend_entry_t      head, push_entry;

  assign is_br      = if_valid && (if_opcode == OPC_BRANCH);
  assign idx        = if_pc[IDX_W+1:2] ^ ((MODE != 0) ? ghr_q : '0);
  assign pred_taken = is_br & pht_q[idx][1];

  assign resolve  = res_valid & ~q_empty;
  assign mispred  = resolve & (res_taken != head.pred);
  assign flush    = mispred;
  // A correct resolve frees the head slot this cycle, so a full queue can still accept.
  assign push      = is_br & CE & ~mispred & (~q_full | resolve);
  assign stall_req = is_br & q_full & ~resolve;

  assign head_idx    = head.idx[IDX_W-1:0];
  assign redirect_pc = res_taken ? head.target[PC_W-1:0] : head.fallthrough[PC_W-1:0];

  always_comb begin
    push_entry             = '0;
    push_entry.idx         = IDX_W_MAX'(idx);
    push_entry.pred        = pred_taken;
    push_entry.fallthrough = PC_W_MAX'(if_pc + PC_W'(4));
    push_entry.target      = PC_W_MAX'(if_target);
    push_entry.ghr         = IDX_W_MAX'(ghr_q);
  end

  always_comb begin
    pc_sel = SEL_PC4;
    if (mispred)         pc_sel = SEL_REDIR;
    else if (pred_taken) pc_sel = SEL_TGT;
  end

  always_comb begin
    ghr_d = ghr_q;
    if (MODE != 0) begin
      if (mispred)   ghr_d = {head.ghr[IDX_W-2:0], res_taken};
      else if (push) ghr_d = {ghr_q[IDX_W-2:0], pred_taken};
    end
    br_cnt_d  = br_cnt_q + 16'(resolve);
    mis_cnt_d = mis_cnt_q + 16'(mispred);
    res_err_d = res_err_q | (res_valid & q_empty);
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values, which
  // is what gives IF the old counter when a resolve writes the index it is reading.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      res_err_q <= 1'b0;
    end else begin
      ghr_q     <= ghr_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      res_err_q <= res_err_d;
    end
  end

  // The table is reset explicitly: predictions must start from weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_CTR; i++) pht_q[i] <= CTR_WNT;
    end else if (resolve) begin
      pht_q[head_idx] <= ctr_next(pht_q[head_idx], res_taken);
    end
  end

  bpu_pend_fifo #(.DEPTH(PEND_DEPTH)) u_pend_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (mispred),
    .push_i      (push),
    .pop_i       (resolve),
    .push_data_i (push_entry),
    .head_o      (head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
  assign res_err = res_err_q;

  logic unused_head;
  assign unused_head = ^{head.idx, head.ghr, head.target, head.fallthrough};

endmodule
